// File: rtl/picorv32_arb_pkg.sv
// picorv32_arb_pkg: shared FSM state, latched request struct and error-counter width for the memory arbiter
package picorv32_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} arb_state_e;
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_req_t;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/picorv32_arb_timer.sv
// picorv32_arb_timer: clearable watchdog up-counter (clk, resetn, clr, en in; tc out when count == TIMEOUT_CYC-1)
module picorv32_arb_timer
  import picorv32_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!resetn || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign tc = cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: round-robin 2:1 native-bus arbiter with latched fields and timeout abort (req0/req1 in, mem_* out, timeout_err/err_count status)
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYC   = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  input  logic                 req0_instr,
  input  logic [31:0]          req0_addr,
  input  logic [31:0]          req0_wdata,
  input  logic [3:0]           req0_wstrb,
  output logic                 req0_ready,
  output logic [31:0]          req0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_instr,
  input  logic [31:0]          req1_addr,
  input  logic [31:0]          req1_wdata,
  input  logic [3:0]           req1_wstrb,
  output logic                 req1_ready,
  output logic [31:0]          req1_rdata,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic                 timeout_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  arb_state_e state;
  arb_req_t   lat;
  logic       last_grant, tc, in_grant, pick1, ab0, ab1;
  assign in_grant = state == GRANT0 || state == GRANT1;
  // on a tie the requester that did not win last time is chosen
  assign pick1 = req1_valid && (!req0_valid || last_grant == 1'b0);
  // last_grant already names the aborted requester while in ABORT
  assign ab0 = state == ABORT && !last_grant;
  assign ab1 = state == ABORT && last_grant;
  picorv32_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .clr   (!in_grant),
    .en    (in_grant && !mem_ready),
    .tc    (tc)
  );
  always_ff @(posedge clk)
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat        <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE:
          if (req0_valid || req1_valid) begin
            lat   <= pick1 ? arb_req_t'{instr: req1_instr, addr: req1_addr, wdata: req1_wdata, wstrb: req1_wstrb}
                           : arb_req_t'{instr: req0_instr, addr: req0_addr, wdata: req0_wdata, wstrb: req0_wstrb};
            state <= pick1 ? GRANT1 : GRANT0;
          end
        GRANT0, GRANT1:
          if (mem_ready) begin
            last_grant <= state == GRANT1;
            state      <= IDLE;
          end else if (tc) begin
            last_grant <= state == GRANT1;
            state      <= ABORT;
            err_count  <= (err_count == '1) ? err_count : err_count + ERR_CNT_W'(1);
          end
        default: state <= IDLE;
      endcase
    end
  assign mem_valid   = in_grant;
  assign mem_instr   = lat.instr;
  assign mem_addr    = lat.addr;
  assign mem_wdata   = lat.wdata;
  assign mem_wstrb   = lat.wstrb;
  assign timeout_err = state == ABORT;
  assign req0_ready  = (state == GRANT0 && mem_ready) || ab0;
  assign req1_ready  = (state == GRANT1 && mem_ready) || ab1;
  assign req0_rdata  = state == GRANT0 ? mem_rdata : ab0 ? TIMEOUT_RDATA : '0;
  assign req1_rdata  = state == GRANT1 ? mem_rdata : ab1 ? TIMEOUT_RDATA : '0;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: directed self-checking bench for the round-robin memory arbiter with an 8-cycle watchdog
module tb_picorv32_mem_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req0_instr = 1'b0, req0_ready;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req0_rdata;
  logic [3:0]  req0_wstrb = '0;
  logic        req1_valid = 1'b0, req1_instr = 1'b0, req1_ready;
  logic [31:0] req1_addr = '0, req1_wdata = '0, req1_rdata;
  logic [3:0]  req1_wstrb = '0;
  logic        mem_valid, mem_instr, mem_ready = 1'b0, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic [7:0]  err_count;
  int passed = 0, total = 0;
  int n0 = 0, n1 = 0, aborts = 0;

  picorv32_mem_arbiter #(.TIMEOUT_CYC(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_wstrb(req0_wstrb), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_wstrb(req1_wstrb), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    tick();
    tick();
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata0", req0_rdata, 0);
    resetn = 1'b1;
    // single read from req0
    req0_valid = 1'b1; req0_addr = 32'h100; req0_wstrb = 4'h0;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("rd_mem_valid", 32'(mem_valid), 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rd_wait_ready0", 32'(req0_ready), 0);
    tick();
    tick();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rd_ready0", 32'(req0_ready), 1);
    chk("rd_rdata0", req0_rdata, 32'h1234_5678);
    chk("rd_ready1", 32'(req1_ready), 0);
    chk("rd_rdata1", req1_rdata, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("rd_idle_valid", 32'(mem_valid), 0);
    // tie after reset: req0 first, req1 at k+2
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h200;
    req1_valid = 1'b1; req1_addr = 32'h300;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0AAA;
    #1;
    chk("tie_valid_t1", 32'(mem_valid), 1);
    chk("tie_first_addr", mem_addr, 32'h200);
    chk("tie_first_ready0", 32'(req0_ready), 1);
    chk("tie_first_ready1", 32'(req1_ready), 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("tie_k1_valid", 32'(mem_valid), 0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0BBB;
    #1;
    chk("tie_k2_valid", 32'(mem_valid), 1);
    chk("tie_second_addr", mem_addr, 32'h300);
    chk("tie_second_ready1", 32'(req1_ready), 1);
    chk("tie_second_rdata1", req1_rdata, 32'h0000_0BBB);
    chk("tie_second_ready0", 32'(req0_ready), 0);
    tick();
    mem_ready = 1'b0;
    // round-robin fairness over 20 back-to-back transactions
    for (int i = 0; i < 20; i++) begin
      tick();
      mem_ready = 1'b1;
      #1;
      chk("rr_grant", 32'(req1_ready), 32'(i % 2));
      n0 += int'(req0_ready);
      n1 += int'(req1_ready);
      tick();
      mem_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count0", 32'(n0), 10);
    chk("rr_count1", 32'(n1), 10);
    // field latching on a req1 write
    req1_valid = 1'b1; req1_addr = 32'h400; req1_wdata = 32'hCAFE_F00D; req1_wstrb = 4'b0011;
    tick();
    req1_valid = 1'b0; req1_addr = 32'h999; req1_wdata = 32'h0; req1_wstrb = 4'hF;
    #1;
    chk("lat_addr", mem_addr, 32'h400);
    chk("lat_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("lat_wstrb", 32'(mem_wstrb), 32'h3);
    tick();
    #1;
    chk("lat_addr_hold", mem_addr, 32'h400);
    chk("lat_wdata_hold", mem_wdata, 32'hCAFE_F00D);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0;
    #1;
    chk("lat_wstrb_hold", 32'(mem_wstrb), 32'h3);
    chk("lat_ready1", 32'(req1_ready), 1);
    tick();
    mem_ready = 1'b0;
    // timeout with no mem_ready
    req0_valid = 1'b1; req0_addr = 32'h500; req0_wstrb = 4'h0;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("to_g7_valid", 32'(mem_valid), 1);
    chk("to_g7_err", 32'(timeout_err), 0);
    tick();
    #1;
    chk("to_ready0", 32'(req0_ready), 1);
    chk("to_rdata0", req0_rdata, 32'hDEAD_BEEF);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_mem_valid", 32'(mem_valid), 0);
    chk("to_err_count", 32'(err_count), 1);
    chk("to_ready1", 32'(req1_ready), 0);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    chk("stray_ready0", 32'(req0_ready), 0);
    chk("stray_rdata0", req0_rdata, 0);
    chk("stray_err", 32'(timeout_err), 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("stray_mem_valid", 32'(mem_valid), 0);
    chk("stray_err_count", 32'(err_count), 1);
    // mem_ready exactly at terminal count wins
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    #1;
    chk("tc_ready0", 32'(req0_ready), 1);
    chk("tc_rdata0", req0_rdata, 32'hA5A5_A5A5);
    chk("tc_err", 32'(timeout_err), 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("tc_after_err", 32'(timeout_err), 0);
    chk("tc_after_valid", 32'(mem_valid), 0);
    chk("tc_err_count", 32'(err_count), 1);
    // 299 further aborts saturate the error counter
    req0_valid = 1'b1;
    for (int c = 0; c < 4000 && aborts < 299; c++) begin
      tick();
      aborts += int'(timeout_err);
    end
    req0_valid = 1'b0;
    chk("sat_aborts_seen", 32'(aborts), 299);
    chk("sat_err_count", 32'(err_count), 255);
    tick();
    tick();
    // reset in the middle of a grant
    req1_valid = 1'b1; req1_addr = 32'h600;
    tick();
    req1_valid = 1'b0;
    #1;
    chk("mrst_grant", 32'(mem_valid), 1);
    resetn = 1'b0;
    tick();
    #1;
    chk("mrst_valid", 32'(mem_valid), 0);
    chk("mrst_ready1", 32'(req1_ready), 0);
    chk("mrst_err_count", 32'(err_count), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-requester arbiter for the PicoRV32 native memory bus. It shares one native-bus port between two masters, for example the CPU and a debug/DMA engine; that port feeds the AXI4-lite adapter. Grants are round-robin. Request fields are latched for the whole transaction. A watchdog aborts any transaction that gets no `mem_ready` within a bounded time.

## Interface
- `TIMEOUT_CYC`, 1024: cycles in a grant state without `mem_ready` before abort; legal range 2..65535.
- `TIMEOUT_RDATA`, 32'hDEAD_BEEF: read data returned to the requester on abort.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `reqN_valid`  in  1  request from requester N, where N = 0/1.
- `reqN_instr`  in  1  instruction-fetch flag.
- `reqN_addr`  in  32  byte address.
- `reqN_wdata`  in  32  write data.
- `reqN_wstrb`  in  4  byte strobes; 0 = read.
- `reqN_ready`  out  1  transaction complete for requester N.
- `reqN_rdata`  out  32  read data for requester N.
- `mem_valid`  out  1  downstream request.
- `mem_instr`  out  1  latched instr flag.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched write data.
- `mem_wstrb`  out  4  latched strobes.
- `mem_ready`  in  1  downstream completion.
- `mem_rdata`  in  32  downstream read data.
- `timeout_err`  out  1  one-cycle pulse on abort.
- `err_count`  out  8  saturating abort counter.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, ABORT.
- IDLE, selection:
  - Only one `reqN_valid` high: select N.
  - Both high: select the requester that was not `last_grant`.
  - Neither high: stay in IDLE.
- IDLE, on selection: register instr/addr/wdata/wstrb from the chosen requester, clear the timer, move to GRANTN.
- GRANTN:
  - `mem_valid`=1; `mem_*` come from the latched registers, never live inputs.
  - `reqN_ready` = `mem_ready` combinationally; `reqN_rdata` = `mem_rdata`.
  - The non-granted requester sees ready=0 and rdata=0.
- GRANTN, on `mem_ready`=1: set `last_grant`=N and go to IDLE.
- GRANTN, timer:
  - The timer increments every GRANT cycle with `mem_ready`=0.
  - At timer == `TIMEOUT_CYC`-1 with `mem_ready`=0, go to ABORT.
  - `mem_ready` arriving in that same cycle wins: normal completion, no abort.
- ABORT (exactly 1 cycle):
  - `mem_valid`=0, which forces the adapter to clear its ack state.
  - `reqN_ready`=1 for the aborted requester, with `reqN_rdata`=`TIMEOUT_RDATA` (also for writes).
  - `timeout_err`=1; `err_count` increments, saturating at 255.
  - `last_grant`=N; next state IDLE.
- A requester dropping `reqN_valid` during its grant is ignored: the latched transaction runs to completion or abort.
- `mem_ready` arriving in IDLE or ABORT (a late response to an aborted transaction) is discarded and not forwarded.

## Timing
- Reset values:
  - State IDLE; `last_grant`=1, so req0 wins the first tie.
  - All `reqN_ready`, `mem_valid`, `timeout_err` = 0.
  - `mem_*` data registers = 0; `reqN_rdata` = 0; `err_count` = 0; timer = 0.
- Grant latency: a request sampled in IDLE at edge T gives `mem_valid`=1 in cycle T+1.
- Completion: `mem_ready` in cycle k gives `reqN_ready` in cycle k (zero latency), with IDLE at k+1.
- Earliest next `mem_valid`: k+2. Back-to-back throughput is 1 transaction per (downstream latency + 2) cycles.
- Timeout: first GRANT cycle is G. Abort happens at G+`TIMEOUT_CYC`, where `reqN_ready` and `timeout_err` pulse. IDLE follows at G+`TIMEOUT_CYC`+1.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and `mem_valid` drops. No ready is issued to the requester.

## Structure
- Package `picorv32_arb_pkg`:
  - `arb_state_e` (IDLE/GRANT0/GRANT1/ABORT).
  - `arb_req_t` struct {instr, addr[31:0], wdata[31:0], wstrb[3:0]}.
  - `ERR_CNT_W`=8.
- Sub-module `picorv32_arb_timer`:
  - Clearable up-counter.
  - Width $clog2(`TIMEOUT_CYC`).
  - Terminal-count output.
- All other logic (FSM, latches, muxing, err counter) stays in the top module.

## Test plan
- Single read: req0 read at addr 0x100; `mem_ready` with rdata 0x12345678 three cycles after `mem_valid`.
  - `mem_addr`=0x100 and `mem_wstrb`=0.
  - `req0_ready` and rdata 0x12345678 in the same cycle; `req1_ready` stays 0.
- Tie after reset: both valid in cycle 0.
  - req0 is granted first and req1 next.
  - `mem_valid` rises at T+1 and again at k+2.
- Round-robin fairness: both held valid for 20 transactions with 1-cycle downstream latency.
  - Grants strictly alternate, 10 each.
- Field latching: req1 write 0xCAFEF00D with wstrb 4'b0011; req1 changes addr/wdata one cycle after the grant.
  - `mem_*` keep the original values until `mem_ready`.
- Timeout: `TIMEOUT_CYC`=8, no `mem_ready`.
  - At G+8: `req0_ready`=1, rdata 0xDEADBEEF, `timeout_err`=1, `mem_valid`=0, `err_count`=1.
  - A stray `mem_ready` at G+9 is ignored.
  - After 300 aborts, `err_count`=255.
- Boundary: `mem_ready` exactly at timer terminal count.
  - Normal completion with downstream rdata; no `timeout_err`; `err_count` unchanged.
